fp_mul_scheduler: RTL and testbench



---
 rtl/fp_mul_scheduler.sv | 139 +++++++++++++
 tb/tb_fp_mul_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_scheduler
// Description : Lets NUM_REQ requesters share one external combinational
//               FP32 multiplier. A round-robin arbiter picks one request per
//               cycle. S1 registers the operands and drives the multiplier
//               directly. S2 registers the product and presents it with the
//               requester's tag on a valid/ready result port.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req_valid/ready   - per-requester handshake (ready one-hot/0)
//               req_a/req_b       - packed operands, requester i at [32i+:32]
//               mul_a/mul_b/mul_p - shared multiplier datapath interface
//               res_valid/ready   - result handshake
//               res_data/res_tag  - product and issuing requester index
//               ops_done          - completed result handshakes (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  input  logic [31:0]             mul_p,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [31:0]             res_data,
  output logic [TAG_W-1:0]        res_tag,
  output logic [31:0]             ops_done
);

  // Pipeline state
  logic             s1_valid_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [31:0]      s1_a_q;
  logic [31:0]      s1_b_q;
  logic             s2_valid_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [31:0]      s2_data_q;
  logic [TAG_W-1:0] ptr_q;
  logic [TAG_W-1:0] ptr_d;
  logic [31:0]      ops_q;

  // Stage enables and arbitration results
  logic             w_s2_en;
  logic             w_s1_en;
  logic             w_any;
  logic [TAG_W-1:0] w_grant_idx;
  logic [TAG_W:0]   w_sum;
  logic             w_accept;

  assign w_s2_en = !s2_valid_q || res_ready;
  assign w_s1_en = !s1_valid_q || w_s2_en;

  // Round-robin search: visit indices ptr, ptr+1, ... modulo NUM_REQ and
  // take the first asserted request. One extra bit on the sum keeps the
  // wrap correct for non-power-of-two NUM_REQ.
  always_comb begin
    w_any       = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, ptr_q} + (TAG_W+1)'(k);
      if (w_sum >= (TAG_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (TAG_W+1)'(NUM_REQ);
      end
      if (!w_any && req_valid[w_sum[TAG_W-1:0]]) begin
        w_any       = 1'b1;
        w_grant_idx = w_sum[TAG_W-1:0];
      end
    end
  end

  // Ready is withheld during reset so nothing is accepted then discarded.
  assign w_accept = w_any && w_s1_en && !rst;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (w_accept) begin
      ptr_d = (w_grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_data_q  <= '0;
      ptr_q      <= '0;
      ops_q      <= '0;
    end else begin
      if (w_s2_en) begin
        s2_valid_q <= s1_valid_q;
        s2_tag_q   <= s1_tag_q;
        s2_data_q  <= mul_p;
      end
      if (w_s1_en) begin
        s1_valid_q <= w_accept;
        // Operands only change on a real accept so the multiplier inputs
        // stay quiet when the stage empties.
        if (w_accept) begin
          s1_tag_q <= w_grant_idx;
          s1_a_q   <= req_a[32*int'(w_grant_idx) +: 32];
          s1_b_q   <= req_b[32*int'(w_grant_idx) +: 32];
        end
      end
      ptr_q <= ptr_d;
      if (s2_valid_q && res_ready) begin
        ops_q <= ops_q + 32'd1;
      end
    end
  end

  assign mul_a     = s1_a_q;
  assign mul_b     = s1_b_q;
  assign res_valid = s2_valid_q;
  assign res_data  = s2_data_q;
  assign res_tag   = s2_tag_q;
  assign ops_done  = ops_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_scheduler
// Description : Self-checking bench for fp_mul_scheduler. Provides a real-
//               arithmetic FP32 multiplier, directed scenarios and a random
//               phase checked against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [31:0]    mul_a, mul_b, mul_p;
  logic           res_valid;
  logic           res_ready;
  logic [31:0]    res_data;
  logic [1:0]     res_tag;
  logic [31:0]    ops_done;

  always #5 clk = ~clk;

  fp_mul_scheduler #(.NUM_REQ(N), .TAG_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .ops_done(ops_done)
  );

  // FP32 <-> double for normal numbers and zero.
  function automatic logic [63:0] f2d(input logic [31:0] a);
    if (a[30:0] == 31'd0) return {a[31], 63'd0};
    return {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    real x, y;
    logic [63:0] d;
    logic [10:0] e;
    x = $bitstoreal(f2d(a));
    y = $bitstoreal(f2d(b));
    d = $realtobits(x * y);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Shared multiplier datapath
  assign mul_p = fmul(mul_a, mul_b);

  // Requester-side state
  logic        rv [N];
  logic [31:0] ra [N];
  logic [31:0] rb [N];
  int          refill;  // 0: drop after accept, 1: new random op, 2: same op

  always_comb begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = rv[i];
      req_a[32*i +: 32] = ra[i];
      req_b[32*i +: 32] = rb[i];
    end
  end

  function automatic logic [31:0] rand_op();
    return {1'($urandom), 8'(110 + $urandom_range(0, 34)), 8'($urandom), 15'd0};
  endfunction

  // Reference model: in-flight operation slots, pointer and counter
  int          m_ptr;
  bit          m_s1v, m_s2v;
  logic [1:0]  m_s1t, m_s2t;
  logic [31:0] m_s1a, m_s1b, m_s2p, m_ops;

  int n_cmp = 0;
  int n_fail = 0;

  // Observations from the latest step
  logic [N-1:0] o_ready;
  logic         o_rv;
  logic [31:0]  o_rd;
  logic [1:0]   o_rt;
  logic [31:0]  o_ops;
  int           o_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_s1v = 0; m_s2v = 0; m_s1t = '0; m_s2t = '0;
    m_s1a = '0; m_s1b = '0; m_s2p = '0; m_ops = '0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, then let
  // the requester side react after the edge.
  task automatic step();
    int g;
    int idx;
    logic [N-1:0] exp_ready;
    bit s1en, s2en;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && rv[idx]) g = idx;
    end
    if (rst || (m_s1v && m_s2v && !res_ready)) g = -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;

    o_ready = req_ready; o_rv = res_valid; o_rd = res_data;
    o_rt = res_tag; o_ops = ops_done; o_grant = g;

    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("res_valid", 32'(res_valid), 32'(m_s2v));
    if (m_s2v) begin
      check("res_data", res_data, m_s2p);
      check("res_tag", 32'(res_tag), 32'(m_s2t));
    end
    check("ops_done", ops_done, m_ops);
    if (m_s1v) begin
      check("mul_a", mul_a, m_s1a);
      check("mul_b", mul_b, m_s1b);
    end

    if (rst) begin
      model_reset();
    end else begin
      if (m_s2v && res_ready) m_ops = m_ops + 32'd1;
      s2en = !m_s2v || res_ready;
      s1en = !m_s1v || s2en;
      if (s2en) begin
        m_s2v = m_s1v; m_s2t = m_s1t; m_s2p = fmul(m_s1a, m_s1b);
      end
      if (s1en) begin
        m_s1v = (g >= 0);
        if (g >= 0) begin
          m_s1t = 2'(g); m_s1a = ra[g]; m_s1b = rb[g];
        end
      end
      if (g >= 0) m_ptr = (g + 1) % N;
    end

    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (refill == 0) rv[g] = 1'b0;
      else if (refill == 1) begin ra[g] = rand_op(); rb[g] = rand_op(); end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic all_idle();
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
  endtask

  int grants [7];
  int tags   [7];
  int cnt;

  initial begin
    rst = 1'b1; res_ready = 1'b1; refill = 0;
    for (int i = 0; i < N; i++) begin rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; end
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_res_valid", 32'(o_rv), 32'd0);
    check("rst_ops_done", o_ops, 32'd0);

    // Single op: 2.0 * 3.0
    rv[0] = 1'b1; ra[0] = 32'h40000000; rb[0] = 32'h40400000;
    step();
    check("single_ready", 32'(o_ready), 32'd1);
    step();
    check("single_lat1_valid", 32'(o_rv), 32'd0);
    step();
    check("single_valid", 32'(o_rv), 32'd1);
    check("single_data", o_rd, 32'h40C00000);
    check("single_tag", 32'(o_rt), 32'd0);
    step();
    check("single_ops_done", o_ops, 32'd1);

    // Round-robin fairness with all requesters busy
    do_reset();
    refill = 1;
    for (int i = 0; i < N; i++) begin rv[i] = 1'b1; ra[i] = rand_op(); rb[i] = rand_op(); end
    for (int s = 0; s < 7; s++) begin
      step();
      grants[s] = o_grant;
      tags[s]   = o_rv ? int'(o_rt) : -1;
    end
    for (int s = 0; s < 7; s++) check("rr_grant", 32'(grants[s]), 32'(s % N));
    for (int s = 2; s < 7; s++) check("rr_tag", 32'(tags[s]), 32'((s - 2) % N));
    refill = 0; all_idle();
    repeat (3) step();

    // Pointer skip and wrap: grant 2 leaves ptr=3, then 0 and 1
    do_reset();
    rv[2] = 1'b1; ra[2] = rand_op(); rb[2] = rand_op();
    step();
    check("wrap_first", 32'(o_ready), 32'b0100);
    rv[0] = 1'b1; rv[1] = 1'b1;
    ra[0] = rand_op(); rb[0] = rand_op(); ra[1] = rand_op(); rb[1] = rand_op();
    step();
    check("wrap_to_0", 32'(o_ready), 32'b0001);
    step();
    check("wrap_to_1", 32'(o_ready), 32'b0010);
    repeat (3) step();

    // Backpressure: 1.5 * 1.5 stream with consumer stalled
    do_reset();
    res_ready = 1'b0; refill = 2;
    rv[0] = 1'b1; ra[0] = 32'h3FC00000; rb[0] = 32'h3FC00000;
    for (int s = 0; s < 5; s++) begin
      step();
      check("bp_ready", 32'(o_ready), (s < 2) ? 32'd1 : 32'd0);
      if (s >= 2) begin
        check("bp_valid", 32'(o_rv), 32'd1);
        check("bp_data", o_rd, 32'h40100000);
      end
    end
    refill = 0; all_idle(); res_ready = 1'b1;
    cnt = 0;
    for (int s = 0; s < 4; s++) begin
      step();
      if (o_rv) cnt++;
    end
    check("bp_drain_count", 32'(cnt), 32'd2);
    check("bp_ops_done", o_ops, 32'd2);

    // Sign and tag: requester 2 issues -2.0 * 4.0
    rv[2] = 1'b1; ra[2] = 32'hC0000000; rb[2] = 32'h40800000;
    repeat (3) step();
    check("sign_valid", 32'(o_rv), 32'd1);
    check("sign_data", o_rd, 32'hC1000000);
    check("sign_tag", 32'(o_rt), 32'd2);

    // Reset with both stages full
    res_ready = 1'b0; refill = 1;
    for (int i = 0; i < N; i++) begin rv[i] = 1'b1; ra[i] = rand_op(); rb[i] = rand_op(); end
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0; refill = 0;
    rv[1] = 1'b0; rv[2] = 1'b0;
    step();
    check("midrst_valid", 32'(o_rv), 32'd0);
    check("midrst_ops", o_ops, 32'd0);
    check("midrst_grant", 32'(o_ready), 32'b0001);
    res_ready = 1'b1; all_idle();
    repeat (3) step();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && ($urandom_range(0, 2) == 0)) begin
          rv[i] = 1'b1; ra[i] = rand_op(); rb[i] = rand_op();
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; res_ready = 1'b1; all_idle();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
